// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - CPU-wide types shared by fetch and decode
package cpu_pkg;
  localparam int PC_W = 15;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [15:0]     inst;
  } fetch_st;
endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with flush, used for PC tags and the fetch buffer
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  input  logic                         flush,
  output logic [WIDTH-1:0]             head,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr, wr_ptr;
  logic             do_push, do_pop;

  // a push into a full FIFO is only accepted when a pop frees the slot in the same cycle
  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != CW'(DEPTH)) || do_pop);
  assign head    = mem[rd_ptr];

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end
endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - Hack CPU fetch stage: PC, in-order imem requests, fetch buffer, redirect
module instr_fetch
  import cpu_pkg::*;
#(
  parameter int PC_W  = cpu_pkg::PC_W,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvld,
  input  logic [15:0]     imem_rdata,
  output fetch_st         fetched_info,
  output logic            fetched_vld,
  input  logic            fetched_gnt,
  input  logic            invalidate,
  input  logic [PC_W-1:0] redirect_pc
);
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                     state, state_nxt;
  logic [PC_W-1:0]            pc, tag_head;
  logic [CW-1:0]              outstanding, outstanding_nxt, drop_cnt, drop_nxt;
  logic [CW-1:0]              tag_count, buf_count;
  logic [CW:0]                credit_used;
  logic                       grant, rsp_ok, rsp_keep, buf_pop;
  logic [$bits(fetch_st)-1:0] buf_head;
  fetch_st                    buf_in;

  assign grant       = imem_req & imem_gnt;
  assign rsp_ok      = imem_rvld && (outstanding != '0);
  assign rsp_keep    = rsp_ok && (state == RUN) && !invalidate;
  assign fetched_vld = (buf_count != '0);
  assign buf_pop     = fetched_vld & fetched_gnt;

  // the slot freed by this cycle's pop is reusable at once, so k=1 streams at full rate
  assign credit_used = {1'b0, outstanding} + {1'b0, buf_count} - (CW+1)'(buf_pop);
  assign imem_req    = (state == RUN) && !invalidate && (credit_used < (CW+1)'(DEPTH));
  assign imem_addr   = pc;

  assign outstanding_nxt = outstanding + CW'(grant) - CW'(rsp_ok);
  assign buf_in          = '{pc: tag_head, inst: imem_rdata};
  assign fetched_info    = fetched_vld ? fetch_st'(buf_head) : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      pc          <= '0;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      state       <= state_nxt;
      outstanding <= outstanding_nxt;
      drop_cnt    <= drop_nxt;
      if (invalidate)  pc <= redirect_pc;
      else if (grant)  pc <= pc + PC_W'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    drop_nxt  = drop_cnt;
    if (invalidate) begin
      // everything still owed by memory after this cycle is stale
      drop_nxt  = outstanding_nxt;
      state_nxt = (outstanding_nxt != '0) ? DRAIN : RUN;
    end else begin
      case (state)
        IDLE:    state_nxt = RUN;
        RUN:     state_nxt = RUN;
        DRAIN: begin
          if (rsp_ok) drop_nxt = drop_cnt - CW'(1);
          if (drop_nxt == '0) state_nxt = RUN;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  sync_fifo #(.WIDTH(PC_W), .DEPTH(DEPTH)) u_tag_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (grant),
    .push_data (pc),
    .pop       (rsp_keep),
    .flush     (invalidate),
    .head      (tag_head),
    .count     (tag_count)
  );

  sync_fifo #(.WIDTH($bits(fetch_st)), .DEPTH(DEPTH)) u_out_buf (
    .clk       (clk),
    .rst       (rst),
    .push      (rsp_keep),
    .push_data (buf_in),
    .pop       (buf_pop),
    .flush     (invalidate),
    .head      (buf_head),
    .count     (buf_count)
  );

  a_no_orphan_rsp: assert property (@(posedge clk) disable iff (rst)
    !(imem_rvld && (outstanding == '0)));

  a_tags_track: assert property (@(posedge clk) disable iff (rst)
    (state != RUN) || (tag_count == outstanding));
endmodule
